// File: rtl/mfp_ahb_bot_hub_pkg.sv
// mfp_ahb_bot_hub_pkg: shared constants for the multi-bot AHB-Lite hub.
// Register offsets, STATUS bit positions, decoder base and a STATUS packer.
package mfp_ahb_bot_hub_pkg;

    localparam logic [1:0] MFP_BOTHUB_CTRL   = 2'd0;
    localparam logic [1:0] MFP_BOTHUB_INFO   = 2'd1;
    localparam logic [1:0] MFP_BOTHUB_STATUS = 2'd2;
    localparam logic [1:0] MFP_BOTHUB_UPDCNT = 2'd3;

    localparam int MFP_BOTHUB_PEND = 0;
    localparam int MFP_BOTHUB_OVR  = 1;
    localparam int MFP_BOTHUB_IE   = 8;

    localparam logic [31:0] MFP_BOTHUB_BASE = 32'h1f80_2000;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [31:0] status_word(
        input logic pend,
        input logic ovr,
        input logic ie
    );
        logic [31:0] w;
        w                  = '0;
        w[MFP_BOTHUB_PEND] = pend;
        w[MFP_BOTHUB_OVR]  = ovr;
        w[MFP_BOTHUB_IE]   = ie;
        return w;
    endfunction

endpackage

// File: rtl/mfp_bot_chan.sv
// mfp_bot_chan: one bot channel (CTRL, INFO snapshot, PEND/OVR/IE, ACK).
// UPDCNT counter only exists when MFP_BOTHUB_UPDCNT_EN is defined.
module mfp_bot_chan
    import mfp_ahb_bot_hub_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int INFO_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ctrl,
    input  logic              wr_status,
    input  logic [31:0]       wdata,
    input  logic [INFO_W-1:0] info_in,
    input  logic              updt_sync,
    input  logic [1:0]        rd_off,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ack,
    output logic              irq,
    output logic [31:0]       rd_data
);

    logic              sync_q;
    logic              updt_edge;
    logic              pend_clr;
    logic              collide;
    logic              pend, pend_nx;
    logic              ovr, ovr_nx;
    logic              ie, ie_nx;
    logic [CTRL_W-1:0] ctrl_nx;
    logic [INFO_W-1:0] info, info_nx;
    logic [15:0]       updcnt_nx;
    logic [31:0]       unused_wdata;

    assign unused_wdata = wdata;

    assign updt_edge = updt_sync & ~sync_q;
    assign pend_clr  = wr_status & wdata[MFP_BOTHUB_PEND];
    assign collide   = updt_edge & pend_clr;
    assign irq       = pend & ie;

    // Next-state values; also feed the read mux so a read right after a
    // write sees the freshly written value.
    always_comb begin
        ctrl_nx = wr_ctrl ? wdata[CTRL_W-1:0] : ctrl;
        info_nx = updt_edge ? info_in : info;
        ie_nx   = wr_status ? wdata[MFP_BOTHUB_IE] : ie;
        pend_nx = pend;
        ovr_nx  = ovr;
        if (updt_edge) begin
            pend_nx = 1'b1;
        end else if (pend_clr) begin
            pend_nx = 1'b0;
        end
        if (collide) begin
            ovr_nx = ovr;
        end else if (updt_edge && pend) begin
            ovr_nx = 1'b1;
        end else if (wr_status && wdata[MFP_BOTHUB_OVR]) begin
            ovr_nx = 1'b0;
        end
    end

    // Channel state registers and the one-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            ctrl   <= '0;
            info   <= '0;
            pend   <= 1'b0;
            ovr    <= 1'b0;
            ie     <= 1'b0;
            ack    <= 1'b0;
        end else begin
            sync_q <= updt_sync;
            ctrl   <= ctrl_nx;
            info   <= info_nx;
            pend   <= pend_nx;
            ovr    <= ovr_nx;
            ie     <= ie_nx;
            ack    <= pend_clr;
        end
    end

`ifdef MFP_BOTHUB_UPDCNT_EN
    logic [15:0] updcnt;

    assign updcnt_nx = updt_edge ? updcnt + 16'd1 : updcnt;

    // Wrapping count of update events.
    always_ff @(posedge clk) begin
        if (rst) begin
            updcnt <= '0;
        end else begin
            updcnt <= updcnt_nx;
        end
    end
`else
    assign updcnt_nx = '0;
`endif

    // Per-channel register read mux.
    always_comb begin
        rd_data = '0;
        case (rd_off)
            MFP_BOTHUB_CTRL:   rd_data = 32'(ctrl_nx);
            MFP_BOTHUB_INFO:   rd_data = 32'(info_nx);
            MFP_BOTHUB_STATUS: rd_data = status_word(pend_nx, ovr_nx, ie_nx);
            default:           rd_data = 32'(updcnt_nx);
        endcase
    end

endmodule

// File: rtl/mfp_ahb_bot_hub.sv
// mfp_ahb_bot_hub: AHB-Lite slave hosting N_BOTS Rojobot channels + IRQ.
// Optional UPDCNT counters are built when MFP_BOTHUB_UPDCNT_EN is defined.
module mfp_ahb_bot_hub
    import mfp_ahb_bot_hub_pkg::*;
#(
    parameter int N_BOTS = 2,
    parameter int CTRL_W = 8,
    parameter int INFO_W = 32
) (
    input  logic                     HCLK,
    input  logic                     SI_Reset,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [N_BOTS*CTRL_W-1:0] IO_BotCtrl,
    input  logic [N_BOTS*INFO_W-1:0] IO_BotInfo,
    input  logic [N_BOTS-1:0]        IO_BotUpdt_Sync,
    output logic [N_BOTS-1:0]        IO_INT_ACK,
    output logic                     IO_Int
);

    logic              valid_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [4:0]        addr_q;
    logic              wr_word;
    logic [2:0]        wchan;
    logic [1:0]        woff;
    logic              rd_req;
    logic [31:0]       rd_word;
    logic [N_BOTS-1:0] irq;
    logic [31:0]       ch_rdata [N_BOTS];
    logic              unused_bus;

    assign unused_bus = ^{HADDR[31:7], HADDR[1:0], HTRANS[0]};

    assign HREADY = 1'b1;
    assign HRESP  = 1'b0;
    assign IO_Int = |irq;

    assign wr_word = valid_q & hwrite_q & (hsize_q == HSIZE_WORD);
    assign wchan   = addr_q[4:2];
    assign woff    = addr_q[1:0];
    assign rd_req  = HSEL & HTRANS[1] & ~HWRITE;

    // Address-phase capture; cleared on reset so a pending data phase is lost.
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            valid_q  <= 1'b0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            addr_q   <= '0;
        end else begin
            valid_q  <= HSEL & HTRANS[1];
            hwrite_q <= HWRITE;
            hsize_q  <= HSIZE;
            addr_q   <= HADDR[6:2];
        end
    end

    for (genvar k = 0; k < N_BOTS; k++) begin : g_chan
        logic sel;
        assign sel = wr_word & (wchan == 3'(k));

        mfp_bot_chan #(
            .CTRL_W(CTRL_W),
            .INFO_W(INFO_W)
        ) u_chan (
            .clk      (HCLK),
            .rst      (SI_Reset),
            .wr_ctrl  (sel & (woff == MFP_BOTHUB_CTRL)),
            .wr_status(sel & (woff == MFP_BOTHUB_STATUS)),
            .wdata    (HWDATA),
            .info_in  (IO_BotInfo[k*INFO_W +: INFO_W]),
            .updt_sync(IO_BotUpdt_Sync[k]),
            .rd_off   (HADDR[3:2]),
            .ctrl     (IO_BotCtrl[k*CTRL_W +: CTRL_W]),
            .ack      (IO_INT_ACK[k]),
            .irq      (irq[k]),
            .rd_data  (ch_rdata[k])
        );
    end

    // Channel select for reads; unpopulated channels read as zero.
    always_comb begin
        rd_word = '0;
        if (rd_req) begin
            for (int i = 0; i < N_BOTS; i++) begin
                if (HADDR[6:4] == 3'(i)) begin
                    rd_word = ch_rdata[i];
                end
            end
        end
    end

    // Registered read data, presented in the data phase.
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            HRDATA <= '0;
        end else begin
            HRDATA <= rd_word;
        end
    end

endmodule
